// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: instruction/data memories for a single-cycle CPU plus a byte-serial program loader.
module cpu_mem_responder #(
  parameter int AW    = 8,
  parameter int IW    = 16,
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] PC,
  output logic [IW-1:0] IR,
  input  logic [AW-1:0] Address_out,
  input  logic [DW-1:0] Data_out,
  input  logic          MW,
  output logic [DW-1:0] Data_in,
  output logic          cpu_reset,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic [AW-1:0] ld_words,
  output logic          ld_err
);
  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, FLUSH, RUN} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          acc, imem_we, dmem_we;
  logic [IW-1:0] imem [DEPTH];
  logic [DW-1:0] dmem [DEPTH];
  assign IR        = imem[PC];
  assign Data_in   = dmem[Address_out];
  assign cpu_reset = state_q != RUN;
  assign ld_ready  = ready_q;
  assign ld_words  = addr_q;
  assign ld_err    = err_q;
  assign acc       = ld_valid && ready_q;
  assign dmem_we   = MW && state_q == RUN;
  // ld_start wins over a byte accepted in the same cycle; that byte is dropped
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    err_d   = err_q;
    imem_we = 1'b0;
    if (ld_start) begin
      state_d = LOAD_HI;
      addr_d  = '0;
      err_d   = 1'b0;
    end else if (acc && state_q == LOAD_HI) begin
      hold_d  = ld_data;
      err_d   = err_q | ld_last;
      state_d = ld_last ? IDLE : LOAD_LO;
    end else if (acc && state_q == LOAD_LO) begin
      imem_we = 1'b1;
      addr_d  = addr_q + 1'b1;
      err_d   = err_q | (&addr_q);
      state_d = ld_last ? FLUSH : LOAD_HI;
    end else if (state_q == FLUSH) begin
      state_d = RUN;
    end
    ready_d = state_d == LOAD_HI || state_d == LOAD_LO;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end
  always_ff @(posedge clk) begin
    if (imem_we) imem[addr_q] <= {hold_q, ld_data};
    if (dmem_we) dmem[Address_out] <= Data_out;
  end
endmodule
